cl_ocl_timeout_guard: RTL and testbench

CL_OCL_TIMEOUT_GUARD -- requirements
Module: cl_ocl_timeout_guard

---
 rtl/cl_ocl_timeout_guard_if.sv | 31 +++
 rtl/cl_ocl_timeout_guard.sv | 275 +++++++++++++++++++++++++++
 tb/tb_cl_ocl_timeout_guard.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cl_ocl_timeout_guard_if.sv
// AXI-Lite register channel bundle (32-bit addr/data) shared by the OCL guard's upstream and downstream sides.
// master drives addresses, write data and response readies; slave drives the ready/response side.
interface cl_ocl_timeout_guard_if;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/cl_ocl_timeout_guard.sv
// Purpose: completes every OCL AXI-Lite access, answering SLVERR (reads: TO_RDATA) when the CL slave stalls; OCL_GUARD_STATUS_EN adds timeout counters.
// Latency: 1 cycle upstream accept -> downstream valid, 1 cycle downstream response -> upstream valid.
// Backpressure: one outstanding write and one read; new accesses are held off until the downstream side has fully retired.
module cl_ocl_timeout_guard #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] TO_RDATA       = 32'hDEAD_BEEF
) (
   input  logic                          clk_main_a0,
   input  logic                          rst_main_n,
   cl_ocl_timeout_guard_if.slave         s_ocl,
   cl_ocl_timeout_guard_if.master        m_ocl,
   output logic [15:0]                   wr_to_cnt,
   output logic [15:0]                   rd_to_cnt
);

   localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {W_IDLE, W_FWD, W_WAIT, W_RESP, W_DRAIN} wr_state_t;
   typedef enum logic [2:0] {R_IDLE, R_FWD, R_WAIT, R_RESP, R_DRAIN} rd_state_t;

   // Holds the upstream readies low until the first edge after reset release.
   logic live_q;

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) live_q <= 1'b0;
      else             live_q <= 1'b1;
   end

   // ---------------- write path ----------------
   wr_state_t   wr_state_q;
   logic [31:0] wr_addr_q;
   logic [31:0] wr_data_q;
   logic [3:0]  wr_strb_q;
   logic        m_aw_vld_q;
   logic        m_w_vld_q;
   logic        aw_done_q;
   logic        w_done_q;
   logic        b_done_q;
   logic [15:0] wr_tmr_q;
   logic        s_b_vld_q;
   logic [1:0]  s_bresp_q;

   logic wr_accept;
   logic aw_hs;
   logic w_hs;
   logic m_b_rdy;
   logic b_hs;
   logic wr_to_fire;

   assign wr_accept  = live_q && (wr_state_q == W_IDLE) && s_ocl.awvalid && s_ocl.wvalid;
   assign aw_hs      = m_aw_vld_q && m_ocl.awready;
   assign w_hs       = m_w_vld_q && m_ocl.wready;
   // After a timeout the late B beat is swallowed once both request beats are out.
   assign m_b_rdy    = (wr_state_q == W_WAIT) ||
                       (((wr_state_q == W_RESP) || (wr_state_q == W_DRAIN)) &&
                        aw_done_q && w_done_q && !b_done_q);
   assign b_hs       = m_b_rdy && m_ocl.bvalid;
   assign wr_to_fire = ((wr_state_q == W_FWD) || (wr_state_q == W_WAIT)) &&
                       (wr_tmr_q == TMR_LAST) &&
                       !((wr_state_q == W_WAIT) && m_ocl.bvalid);

   assign s_ocl.awready = wr_accept;
   assign s_ocl.wready  = wr_accept;
   assign s_ocl.bvalid  = s_b_vld_q;
   assign s_ocl.bresp   = s_bresp_q;
   assign m_ocl.awaddr  = wr_addr_q;
   assign m_ocl.awvalid = m_aw_vld_q;
   assign m_ocl.wdata   = wr_data_q;
   assign m_ocl.wstrb   = wr_strb_q;
   assign m_ocl.wvalid  = m_w_vld_q;
   assign m_ocl.bready  = m_b_rdy;

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         wr_state_q <= W_IDLE;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_strb_q  <= '0;
         m_aw_vld_q <= 1'b0;
         m_w_vld_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         b_done_q   <= 1'b0;
         wr_tmr_q   <= '0;
         s_b_vld_q  <= 1'b0;
         s_bresp_q  <= '0;
      end else begin
         if (aw_hs) begin
            m_aw_vld_q <= 1'b0;
            aw_done_q  <= 1'b1;
         end
         if (w_hs) begin
            m_w_vld_q <= 1'b0;
            w_done_q  <= 1'b1;
         end
         if (b_hs) b_done_q <= 1'b1;

         case (wr_state_q)
            W_IDLE: begin
               if (wr_accept) begin
                  wr_addr_q  <= s_ocl.awaddr;
                  wr_data_q  <= s_ocl.wdata;
                  wr_strb_q  <= s_ocl.wstrb;
                  m_aw_vld_q <= 1'b1;
                  m_w_vld_q  <= 1'b1;
                  aw_done_q  <= 1'b0;
                  w_done_q   <= 1'b0;
                  b_done_q   <= 1'b0;
                  wr_tmr_q   <= '0;
                  wr_state_q <= W_FWD;
               end
            end
            W_FWD: begin
               wr_tmr_q <= wr_tmr_q + 16'd1;
               if (wr_to_fire) begin
                  s_b_vld_q  <= 1'b1;
                  s_bresp_q  <= RESP_SLVERR;
                  wr_state_q <= W_RESP;
               end else if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                  wr_state_q <= W_WAIT;
               end
            end
            W_WAIT: begin
               wr_tmr_q <= wr_tmr_q + 16'd1;
               if (m_ocl.bvalid) begin
                  s_b_vld_q  <= 1'b1;
                  s_bresp_q  <= m_ocl.bresp;
                  wr_state_q <= W_RESP;
               end else if (wr_to_fire) begin
                  s_b_vld_q  <= 1'b1;
                  s_bresp_q  <= RESP_SLVERR;
                  wr_state_q <= W_RESP;
               end
            end
            W_RESP: begin
               if (s_ocl.bready) begin
                  s_b_vld_q  <= 1'b0;
                  wr_state_q <= (b_done_q || b_hs) ? W_IDLE : W_DRAIN;
               end
            end
            W_DRAIN: begin
               if (b_hs) wr_state_q <= W_IDLE;
            end
            default: wr_state_q <= W_IDLE;
         endcase
      end
   end

   // ---------------- read path ----------------
   rd_state_t   rd_state_q;
   logic [31:0] rd_addr_q;
   logic        m_ar_vld_q;
   logic        ar_done_q;
   logic        r_done_q;
   logic [15:0] rd_tmr_q;
   logic        s_r_vld_q;
   logic [31:0] s_rdata_q;
   logic [1:0]  s_rresp_q;

   logic rd_accept;
   logic ar_hs;
   logic m_r_rdy;
   logic r_hs;
   logic rd_to_fire;

   assign rd_accept  = live_q && (rd_state_q == R_IDLE) && s_ocl.arvalid;
   assign ar_hs      = m_ar_vld_q && m_ocl.arready;
   assign m_r_rdy    = (rd_state_q == R_WAIT) ||
                       (((rd_state_q == R_RESP) || (rd_state_q == R_DRAIN)) &&
                        ar_done_q && !r_done_q);
   assign r_hs       = m_r_rdy && m_ocl.rvalid;
   assign rd_to_fire = ((rd_state_q == R_FWD) || (rd_state_q == R_WAIT)) &&
                       (rd_tmr_q == TMR_LAST) &&
                       !((rd_state_q == R_WAIT) && m_ocl.rvalid);

   assign s_ocl.arready = live_q && (rd_state_q == R_IDLE);
   assign s_ocl.rvalid  = s_r_vld_q;
   assign s_ocl.rdata   = s_rdata_q;
   assign s_ocl.rresp   = s_rresp_q;
   assign m_ocl.araddr  = rd_addr_q;
   assign m_ocl.arvalid = m_ar_vld_q;
   assign m_ocl.rready  = m_r_rdy;

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         rd_state_q <= R_IDLE;
         rd_addr_q  <= '0;
         m_ar_vld_q <= 1'b0;
         ar_done_q  <= 1'b0;
         r_done_q   <= 1'b0;
         rd_tmr_q   <= '0;
         s_r_vld_q  <= 1'b0;
         s_rdata_q  <= '0;
         s_rresp_q  <= '0;
      end else begin
         if (ar_hs) begin
            m_ar_vld_q <= 1'b0;
            ar_done_q  <= 1'b1;
         end
         if (r_hs) r_done_q <= 1'b1;

         case (rd_state_q)
            R_IDLE: begin
               if (rd_accept) begin
                  rd_addr_q  <= s_ocl.araddr;
                  m_ar_vld_q <= 1'b1;
                  ar_done_q  <= 1'b0;
                  r_done_q   <= 1'b0;
                  rd_tmr_q   <= '0;
                  rd_state_q <= R_FWD;
               end
            end
            R_FWD: begin
               rd_tmr_q <= rd_tmr_q + 16'd1;
               if (rd_to_fire) begin
                  s_r_vld_q  <= 1'b1;
                  s_rdata_q  <= TO_RDATA;
                  s_rresp_q  <= RESP_SLVERR;
                  rd_state_q <= R_RESP;
               end else if (ar_hs) begin
                  rd_state_q <= R_WAIT;
               end
            end
            R_WAIT: begin
               rd_tmr_q <= rd_tmr_q + 16'd1;
               if (m_ocl.rvalid) begin
                  s_r_vld_q  <= 1'b1;
                  s_rdata_q  <= m_ocl.rdata;
                  s_rresp_q  <= m_ocl.rresp;
                  rd_state_q <= R_RESP;
               end else if (rd_to_fire) begin
                  s_r_vld_q  <= 1'b1;
                  s_rdata_q  <= TO_RDATA;
                  s_rresp_q  <= RESP_SLVERR;
                  rd_state_q <= R_RESP;
               end
            end
            R_RESP: begin
               if (s_ocl.rready) begin
                  s_r_vld_q  <= 1'b0;
                  rd_state_q <= (r_done_q || r_hs) ? R_IDLE : R_DRAIN;
               end
            end
            R_DRAIN: begin
               if (r_hs) rd_state_q <= R_IDLE;
            end
            default: rd_state_q <= R_IDLE;
         endcase
      end
   end

   // ---------------- timeout status ----------------
`ifdef OCL_GUARD_STATUS_EN
   logic [15:0] wr_to_cnt_q;
   logic [15:0] rd_to_cnt_q;

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         wr_to_cnt_q <= '0;
         rd_to_cnt_q <= '0;
      end else begin
         if (wr_to_fire && (wr_to_cnt_q != 16'hFFFF)) wr_to_cnt_q <= wr_to_cnt_q + 16'd1;
         if (rd_to_fire && (rd_to_cnt_q != 16'hFFFF)) rd_to_cnt_q <= rd_to_cnt_q + 16'd1;
      end
   end

   assign wr_to_cnt = wr_to_cnt_q;
   assign rd_to_cnt = rd_to_cnt_q;
`else
   assign wr_to_cnt = 16'h0;
   assign rd_to_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_cl_ocl_timeout_guard.sv
// Directed bench for cl_ocl_timeout_guard with TIMEOUT_CYCLES = 16; both sides of the guard are driven from here.
// Expected counter values follow OCL_GUARD_STATUS_EN so the bench matches either build.
module tb_cl_ocl_timeout_guard;

   localparam int unsigned TO = 16;
`ifdef OCL_GUARD_STATUS_EN
   localparam logic [31:0] CNT_ONE = 32'd1;
`else
   localparam logic [31:0] CNT_ONE = 32'd0;
`endif

   logic        clk_main_a0 = 1'b0;
   logic        rst_main_n  = 1'b0;
   logic [15:0] wr_to_cnt;
   logic [15:0] rd_to_cnt;

   always #5 clk_main_a0 = ~clk_main_a0;

   cl_ocl_timeout_guard_if s_if ();
   cl_ocl_timeout_guard_if m_if ();

   cl_ocl_timeout_guard #(
      .TIMEOUT_CYCLES (TO),
      .TO_RDATA       (32'hDEAD_BEEF)
   ) u_dut (
      .clk_main_a0 (clk_main_a0),
      .rst_main_n  (rst_main_n),
      .s_ocl       (s_if),
      .m_ocl       (m_if),
      .wr_to_cnt   (wr_to_cnt),
      .rd_to_cnt   (rd_to_cnt)
   );

   int n_run  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_main_a0);
   endtask

   // Presents a write upstream and returns at the first negedge after acceptance.
   task automatic host_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bit ok;
      ok = 1'b0;
      s_if.awaddr = a; s_if.wdata = d; s_if.wstrb = s;
      s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         #1 ok = s_if.awready;
         tick();
      end
      s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
      chk("wr_accept", 32'(ok), 32'd1);
   endtask

   task automatic host_rd(input logic [31:0] a);
      bit ok;
      ok = 1'b0;
      s_if.araddr = a; s_if.arvalid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         #1 ok = s_if.arready;
         tick();
      end
      s_if.arvalid = 1'b0;
      chk("rd_accept", 32'(ok), 32'd1);
   endtask

   int lat;
   int cnt_a;
   int cnt_b;

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      s_if.awaddr = '0; s_if.awvalid = 0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wvalid = 0;
      s_if.bready = 1; s_if.araddr = '0; s_if.arvalid = 0; s_if.rready = 1;
      m_if.awready = 0; m_if.wready = 0; m_if.bresp = '0; m_if.bvalid = 0;
      m_if.arready = 1; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 0;

      // Reset state, with upstream valids already asserted
      s_if.awvalid = 1; s_if.wvalid = 1; s_if.arvalid = 1;
      repeat (3) tick();
      chk("rst_awready", 32'(s_if.awready), 0);
      chk("rst_arready", 32'(s_if.arready), 0);
      chk("rst_valids",  32'({s_if.bvalid, s_if.rvalid, m_if.awvalid, m_if.wvalid, m_if.arvalid}), 0);
      chk("rst_readies", 32'({m_if.bready, m_if.rready}), 0);
      chk("rst_rdata",   s_if.rdata, 0);
      chk("rst_cnt",     32'({wr_to_cnt, rd_to_cnt}), 0);
      s_if.awvalid = 0; s_if.wvalid = 0; s_if.arvalid = 0;
      rst_main_n = 1;
      repeat (2) tick();

      // Normal write, downstream readies delayed, bresp 0 three cycles after W_WAIT
      host_wr(32'h0000_0500, 32'h1234_5678, 4'hF);
      chk("w1_awvalid", 32'(m_if.awvalid), 1);
      chk("w1_addr",    m_if.awaddr, 32'h0000_0500);
      chk("w1_data",    m_if.wdata,  32'h1234_5678);
      chk("w1_strb",    32'(m_if.wstrb), 32'hF);
      tick();
      chk("w1_aw_hold", 32'({m_if.awvalid, m_if.wvalid}), 32'b11);
      m_if.awready = 1;
      tick();
      m_if.awready = 0;
      chk("w1_aw_drop", 32'({m_if.awvalid, m_if.wvalid}), 32'b01);
      m_if.wready = 1;
      tick();
      m_if.wready = 0;
      chk("w1_bready", 32'(m_if.bready), 1);
      repeat (3) tick();
      m_if.bvalid = 1; m_if.bresp = 2'b00;
      tick();
      m_if.bvalid = 0;
      chk("w1_bvalid", 32'(s_if.bvalid), 1);
      chk("w1_bresp",  32'(s_if.bresp), 0);
      tick();
      chk("w1_bdone",  32'(s_if.bvalid), 0);
      chk("w1_tocnt",  32'(wr_to_cnt), 0);
      m_if.awready = 1; m_if.wready = 1;

      // Read timeout: slave never returns data
      host_rd(32'h0000_0500);
      chk("r2_araddr", m_if.araddr, 32'h0000_0500);
      lat = -1;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         if (s_if.rvalid) lat = k;
         else tick();
      end
      chk("r2_latency", 32'(lat), 32'(TO));
      chk("r2_rdata",   s_if.rdata, 32'hDEAD_BEEF);
      chk("r2_rresp",   32'(s_if.rresp), 2);
      chk("r2_tocnt",   32'(rd_to_cnt), CNT_ONE);
      tick();
      chk("r2_drain_rvalid", 32'(s_if.rvalid), 0);
      chk("r2_drain_rready", 32'(m_if.rready), 1);
      chk("r2_drain_arrdy",  32'(s_if.arready), 0);
      m_if.rvalid = 1; m_if.rdata = 32'h1111_1111;
      tick();
      m_if.rvalid = 0;
      chk("r2_late_absorb", 32'(s_if.rvalid), 0);
      chk("r2_idle_arrdy",  32'(s_if.arready), 1);

      // Read where m_rvalid lands in the timeout cycle
      host_rd(32'h0000_0508);
      for (int k = 0; k < 15; k++) tick();
      chk("r3_pre_rvalid", 32'(s_if.rvalid), 0);
      chk("r3_rready",     32'(m_if.rready), 1);
      m_if.rvalid = 1; m_if.rdata = 32'hCAFE_F00D; m_if.rresp = 2'b00;
      tick();
      m_if.rvalid = 0;
      chk("r3_rvalid", 32'(s_if.rvalid), 1);
      chk("r3_rdata",  s_if.rdata, 32'hCAFE_F00D);
      chk("r3_rresp",  32'(s_if.rresp), 0);
      chk("r3_tocnt",  32'(rd_to_cnt), CNT_ONE);
      tick();

      // Write timeout, late bvalid five cycles after, new write held until drain done
      host_wr(32'h0000_0500, 32'h0BAD_0BAD, 4'h1);
      lat = -1;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         if (s_if.bvalid) lat = k;
         else tick();
      end
      chk("w4_latency", 32'(lat), 32'(TO));
      chk("w4_bresp",   32'(s_if.bresp), 2);
      chk("w4_tocnt",   32'(wr_to_cnt), CNT_ONE);
      tick();
      s_if.awaddr = 32'h0000_0504; s_if.wdata = 32'h5555_AAAA; s_if.wstrb = 4'hC;
      s_if.awvalid = 1; s_if.wvalid = 1;
      cnt_a = 0; cnt_b = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (s_if.awready) cnt_a++;
         if (s_if.bvalid)  cnt_b++;
         if (!m_if.bready) cnt_b++;
         tick();
      end
      m_if.bvalid = 1; m_if.bresp = 2'b01;
      #1;
      if (s_if.awready) cnt_a++;
      chk("w4_drain_block", 32'(cnt_a), 0);
      chk("w4_drain_bvld",  32'(cnt_b), 0);
      tick();
      m_if.bvalid = 0;
      #1;
      chk("w4_no_2nd_b",  32'(s_if.bvalid), 0);
      chk("w4_reopen",    32'(s_if.awready), 1);
      tick();
      s_if.awvalid = 0; s_if.wvalid = 0;
      chk("w4_new_addr", m_if.awaddr, 32'h0000_0504);
      chk("w4_new_data", m_if.wdata,  32'h5555_AAAA);
      tick();
      m_if.bvalid = 1; m_if.bresp = 2'b01;
      tick();
      m_if.bvalid = 0;
      chk("w4_new_bvalid", 32'(s_if.bvalid), 1);
      chk("w4_new_bresp",  32'(s_if.bresp), 1);
      tick();

      // Reset while waiting on B; stale bvalid after release must not surface
      host_wr(32'h0000_0600, 32'hA5A5_5A5A, 4'h3);
      tick();
      chk("w5_bready", 32'(m_if.bready), 1);
      rst_main_n = 0;
      #1;
      chk("w5_rst_outs", 32'({m_if.bready, m_if.awvalid, s_if.bvalid, s_if.awready}), 0);
      chk("w5_rst_addr", m_if.awaddr, 0);
      tick();
      chk("w5_rst_cnt",  32'({wr_to_cnt, rd_to_cnt}), 0);
      rst_main_n = 1;
      m_if.bvalid = 1; m_if.bresp = 2'b10;
      cnt_b = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (s_if.bvalid || m_if.bready) cnt_b++;
         tick();
      end
      m_if.bvalid = 0;
      chk("w5_no_b_after_rst", 32'(cnt_b), 0);
      host_wr(32'h0000_0604, 32'h0F0F_F0F0, 4'hF);
      chk("w5_new_addr", m_if.awaddr, 32'h0000_0604);
      tick();
      m_if.bvalid = 1; m_if.bresp = 2'b00;
      tick();
      m_if.bvalid = 0;
      chk("w5_new_bvalid", 32'(s_if.bvalid), 1);
      chk("w5_new_bresp",  32'(s_if.bresp), 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
